// File: rtl/enoc_switch_allocator_if.sv
// Handshake bundle between the per-input route calculators/buffers and the switch allocator.
// The allocator connects through the slave modport; the router fabric drives through master.
interface enoc_switch_allocator_if #(
   parameter int N_PORTS = 5
);
   logic                         ce;
   logic [N_PORTS*N_PORTS-1:0]   i_output_req;
   logic [N_PORTS-1:0]           i_val;
   logic [N_PORTS-1:0]           i_tail;
   logic [N_PORTS-1:0]           i_out_en;
   logic [N_PORTS-1:0]           o_input_grant;
   logic [N_PORTS*N_PORTS-1:0]   o_output_sel;
   logic [N_PORTS-1:0]           o_output_val;

   modport master (
      output ce, i_output_req, i_val, i_tail, i_out_en,
      input  o_input_grant, o_output_sel, o_output_val
   );

   modport slave (
      input  ce, i_output_req, i_val, i_tail, i_out_en,
      output o_input_grant, o_output_sel, o_output_val
   );
endinterface

// File: rtl/enoc_switch_allocator.sv
// ENoC switch allocator: per-output round-robin arbitration with a wormhole lock held
// from head to tail; grants and crossbar selects are combinational from the lock state.
module enoc_switch_allocator #(
   parameter int N_PORTS = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   enoc_switch_allocator_if.slave bus
);
   localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   state_e                     state_q [N_PORTS];
   logic [PW-1:0]              owner_q [N_PORTS];
   logic [PW-1:0]              ptr_q   [N_PORTS];

   logic [N_PORTS-1:0]         req_m   [N_PORTS];
   logic [N_PORTS-1:0]         alloc_d;
   logic [PW-1:0]              win_d   [N_PORTS];
   logic [N_PORTS-1:0]         xfer_d;
   logic [N_PORTS-1:0]         grant_d;
   logic [N_PORTS*N_PORTS-1:0] sel_d;

   // Multi-hot requests collapse to their lowest set bit so each input targets one output.
   always_comb begin : decode
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         req_m[i] = '0;
         hit      = 1'b0;
         for (int j = 0; j < N_PORTS; j++) begin
            if (!hit && bus.i_val[i] && bus.i_output_req[i*N_PORTS+j]) begin
               req_m[i][j] = 1'b1;
               hit         = 1'b1;
            end
         end
      end
   end

   always_comb begin : arbitrate
      int idx;
      idx = 0;
      for (int j = 0; j < N_PORTS; j++) begin
         alloc_d[j] = 1'b0;
         win_d[j]   = '0;
         for (int k = 0; k < N_PORTS; k++) begin
            idx = int'(ptr_q[j]) + k;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            if (!alloc_d[j] && req_m[idx][j]) begin
               alloc_d[j] = 1'b1;
               win_d[j]   = PW'(idx);
            end
         end
      end
   end

   // Reset gates the outputs so a lock left over from before reset never leaks a grant.
   always_comb begin : transfer
      xfer_d  = '0;
      grant_d = '0;
      sel_d   = '0;
      for (int j = 0; j < N_PORTS; j++) begin
         if (reset_n && bus.ce && (state_q[j] == LOCKED) && bus.i_out_en[j] &&
             req_m[owner_q[j]][j]) begin
            xfer_d[j]                              = 1'b1;
            grant_d[owner_q[j]]                    = 1'b1;
            sel_d[j*N_PORTS + int'(owner_q[j])]    = 1'b1;
         end
      end
   end

   assign bus.o_input_grant = grant_d;
   assign bus.o_output_sel  = sel_d;
   assign bus.o_output_val  = xfer_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int j = 0; j < N_PORTS; j++) begin
            state_q[j] <= IDLE;
            owner_q[j] <= '0;
            ptr_q[j]   <= '0;
         end
      end else if (bus.ce) begin
         for (int j = 0; j < N_PORTS; j++) begin
            case (state_q[j])
               IDLE: begin
                  if (alloc_d[j]) begin
                     state_q[j] <= LOCKED;
                     owner_q[j] <= win_d[j];
                  end
               end
               LOCKED: begin
                  if (xfer_d[j] && bus.i_tail[owner_q[j]]) begin
                     state_q[j] <= IDLE;
                     ptr_q[j]   <= (owner_q[j] == PW'(N_PORTS-1)) ? '0 : owner_q[j] + PW'(1);
                  end
               end
               default: state_q[j] <= IDLE;
            endcase
         end
      end
   end

   for (genvar j = 0; j < N_PORTS; j++) begin : g_out_chk
      a_sel_onehot0: assert property (@(posedge clk)
         $onehot0(bus.o_output_sel[j*N_PORTS +: N_PORTS]));
      a_val_matches_sel: assert property (@(posedge clk)
         bus.o_output_val[j] == (|bus.o_output_sel[j*N_PORTS +: N_PORTS]));
   end

   for (genvar i = 0; i < N_PORTS; i++) begin : g_in_chk
      logic [N_PORTS-1:0] col;
      for (genvar j = 0; j < N_PORTS; j++) begin : g_col
         assign col[j] = bus.o_output_sel[j*N_PORTS+i];
      end
      a_one_output_per_input: assert property (@(posedge clk) $onehot0(col));
      a_grant_matches_sel: assert property (@(posedge clk) bus.o_input_grant[i] == (|col));
   end
endmodule

// File: doc/enoc_switch_allocator.md
Name: enoc_switch_allocator

Overview:
- Sits directly downstream of the per-input route calculators in each ENoC router.
- Each of the N_PORTS input ports presents a one-hot output-port request. Port index order is 0=c, 1=n, 2=e, 3=s, 4=w, matching the route calculator's [c,n,e,s,w] vector.
- The block arbitrates each output port round-robin among requesting inputs. It locks the output to the winner for a whole wormhole packet (head to tail).
- It drives per-input transfer grants and per-output crossbar selects.

Parameters:
- N_PORTS, 5, number of router ports. The request vector width and index order are fixed by the route calculator.

Ports:
- clk  input  1  clock.
- reset_n  input  1  synchronous, active-low reset.
- ce  input  1  clock enable. When low, the block is frozen and all grants are 0.
- i_output_req  input  N_PORTS*N_PORTS  request vectors. Bits [i*N_PORTS +: N_PORTS] are input i's one-hot output request; bit j within the slice means output j.
- i_val  input  N_PORTS  input i has a valid flit at the head of its buffer.
- i_tail  input  N_PORTS  the flit at input i is a packet tail. A single-flit packet has head and tail in the same flit.
- i_out_en  input  N_PORTS  output j can accept a flit this cycle (downstream credit or not-full).
- o_input_grant  output  N_PORTS  input i transfers its head flit this cycle. The input pops its buffer on this signal.
- o_output_sel  output  N_PORTS*N_PORTS  crossbar select. Bits [j*N_PORTS +: N_PORTS] are a one-hot selection of the input driving output j, and are 0 when unowned.
- o_output_val  output  N_PORTS  output j carries a valid flit this cycle.

Behaviour:
- Request decoding:
  - Input i requests output j when i_val[i] & i_output_req[i*N+j].
  - A multi-hot request is a protocol error; the block honours only the lowest-index set bit.
  - An all-zero request is treated as no request.
- Per-output state, one instance per output j:
  - state: IDLE or LOCKED.
  - owner: log2(N_PORTS) bits, the input that holds the lock.
  - ptr: log2(N_PORTS) bits, the round-robin start index.
- IDLE -> LOCKED:
  - Taken at a clk edge with ce=1 when at least one input requests j.
  - The winner is the first requesting input found searching ptr, ptr+1, ... modulo N_PORTS.
  - owner is set to the winner. No flit moves in the allocation cycle.
- LOCKED behaviour:
  - When i_val[owner] & req(owner→j) & i_out_en[j] & ce, the block asserts o_input_grant[owner], o_output_sel[j][owner] and o_output_val[j] in the same cycle. This is combinational, with zero latency from the inputs.
  - If i_val[owner] is low, i_out_en[j] is low, or the owner's request changes, this is a bubble: no grant is issued and the lock is held.
- LOCKED -> IDLE:
  - Taken at the edge ending a granted cycle in which i_tail[owner]=1.
  - ptr becomes (owner+1) mod N_PORTS.
  - Minimum output occupancy is therefore 1 allocation cycle plus 1 transfer cycle; back-to-back packets on the same output have a 1-cycle gap.
- Simultaneous events: inputs are independent because each requests at most one output. Different outputs may allocate and transfer in the same cycle.
- Requests from non-owners while LOCKED are ignored and cause no state change.
- ce=0: state, owner and ptr hold. o_input_grant, o_output_sel and o_output_val are all 0.
- Reset, including mid-packet:
  - At the edge, all outputs go to IDLE, owner=0, ptr=0.
  - All outputs read 0 while reset_n=0 and during the first cycle after reset.
  - A partially sent packet is abandoned; purging the upstream buffer is the router's responsibility.
- Invariants checked by assertions:
  - Each o_output_sel slice is one-hot or zero.
  - o_input_grant has at most one bit per input.
  - o_output_val[j] equals the OR of its o_output_sel slice.

Test Plan:
- Single packet: input 0 (c) requests e (bit 2), 3 flits, tail on the 3rd, i_out_en=all 1.
  - Cycle 0 allocates; cycles 1-3 assert o_input_grant[0], o_output_sel[e]=00001b and o_output_val[2].
  - Cycle 4 has output e IDLE and ptr[e]=1.
- Contention: inputs n, s and w all request e with single-flit packets and ptr[e]=0.
  - Grant order is n, s, w, each packet separated by one allocation cycle.
  - Afterwards ptr[e]=0 (w+1 wraps).
- Wormhole lock: input n holds e with a 4-flit packet while input s requests e from cycle 1.
  - s gets no grant until n's tail transfers; s is allocated the cycle after.
- Backpressure: input c locked on output s, i_out_en[s]=0 for 3 cycles mid-packet, and i_val bubbles.
  - No grant and no o_output_val in those cycles; the lock is held; the remaining flits transfer after release.
- Parallel and ce: c→n and e→w allocate simultaneously and both transfer in the same cycle.
  - Pulsing ce=0 for 2 cycles zeroes all outputs and freezes progress; flit count is unchanged.
- Reset mid-packet: assert reset_n=0 during flit 2 of a w→c packet.
  - Next cycle all outputs are 0 and all ptrs are 0.
  - A new request from w to c is re-allocated from IDLE.
